// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, state encoding and address map for the RTC read sequencer
// Purpose : funcion_conf codes, sequencer state enum, local-index -> RTC address map,
//           skip ranges per configuration mode and the decoder-default local address.
// Ports   : none (package).
package rtc_pkg;

   // funcion_conf codes
   localparam logic [2:0] FC_NORMAL = 3'b000;
   localparam logic [2:0] FC_HORA   = 3'b001;
   localparam logic [2:0] FC_FECHA  = 3'b010;
   localparam logic [2:0] FC_TIMER  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WAIT_ACK,
      ST_STROBE
   } state_t;

   // Skip ranges; the hora group starts at index 0 and the timer group runs to the
   // last index, so only the inner bounds are needed.
   localparam logic [3:0] HORA_HI  = 4'd2;
   localparam logic [3:0] FECHA_LO = 4'd3;
   localparam logic [3:0] FECHA_HI = 4'd6;
   localparam logic [3:0] TIMER_LO = 4'd7;

   // RTC address bases for the two register blocks
   localparam logic [7:0] RTC_BASE_HF  = 8'h21;
   localparam logic [7:0] RTC_BASE_TMR = 8'h41;

   // Local address presented while no strobe is active; the decoder treats it as "no load"
   localparam logic [3:0] ADDR_IDLE = 4'hF;

   function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
      if (idx < TIMER_LO) begin
         return RTC_BASE_HF + {4'h0, idx};
      end
      return RTC_BASE_TMR + {4'h0, idx - TIMER_LO};
   endfunction

   function automatic logic fc_legal(input logic [2:0] fc);
      return (fc == FC_NORMAL) || (fc == FC_HORA) || (fc == FC_FECHA) || (fc == FC_TIMER);
   endfunction

   // An illegal code skips everything, which ends a sweep early without bus traffic.
   function automatic logic skip_idx(input logic [2:0] fc, input logic [3:0] idx);
      case (fc)
         FC_NORMAL: return 1'b0;
         FC_HORA:   return (idx <= HORA_HI);
         FC_FECHA:  return (idx >= FECHA_LO) && (idx <= FECHA_HI);
         FC_TIMER:  return (idx >= TIMER_LO);
         default:   return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/rtc_timeout_cnt.sv
// rtl/rtc_timeout_cnt.sv - loadable saturating counter flagging an ack timeout
// Purpose : counts WAIT_ACK cycles; expired_o is high during the TIMEOUT-th cycle.
// Ports   : clk, reset (async, active high)
//           load_i    - restart the count for a new request
//           en_i      - count this cycle
//           expired_o - TIMEOUT cycles have been spent waiting, including the current one
module rtc_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load value is 1: the load happens one cycle before waiting begins, so the
   // first waiting cycle already reads 1 and expiry lines up with the TIMEOUT-th cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(1);
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/rtc_lectura_secuenciador.sv
// rtl/rtc_lectura_secuenciador.sv - read sequencer sweeping the local RTC registers
// Purpose : on a read tick, fetches each of N_REGS registers from the RTC bus controller
//           via req/ack and emits one active-low reg_rd strobe per fetched value,
//           skipping the register group selected by funcion_conf.
// Ports   : clk, reset (async, active high)
//           tick_lectura   - sweep start request (single cycle)
//           funcion_conf   - 000 normal, 001 hora, 010 fecha, 100 timer
//           bus_ack        - read ack, bus_data_in valid in the same cycle
//           bus_data_in    - read data
//           bus_req        - read request, held until ack or timeout
//           bus_addr       - RTC address of the current request
//           reg_rd         - active-low one-cycle load strobe
//           addr_mem_local - local address (4'hF outside a strobe)
//           dato_local     - fetched data
//           busy           - sweep in progress
//           error_timeout  - sticky timeout flag, cleared at the next accepted tick
module rtc_lectura_secuenciador
   import rtc_pkg::*;
#(
   parameter int N_REGS  = 10,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_lectura,
   input  logic [2:0]        funcion_conf,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_data_in,
   output logic              bus_req,
   output logic [7:0]        bus_addr,
   output logic              reg_rd,
   output logic [ADDR_W-1:0] addr_mem_local,
   output logic [DATA_W-1:0] dato_local,
   output logic              busy,
   output logic              error_timeout
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              bus_req_q, bus_req_d;
   logic [7:0]        bus_addr_q, bus_addr_d;
   logic              reg_rd_q, reg_rd_d;
   logic [ADDR_W-1:0] addr_local_q, addr_local_d;
   logic [DATA_W-1:0] dato_q, dato_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic cnt_load, cnt_en, cnt_expired;
   logic advance;

   rtc_timeout_cnt #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout_cnt (
      .clk      (clk),
      .reset    (reset),
      .load_i   (cnt_load),
      .en_i     (cnt_en),
      .expired_o(cnt_expired)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      bus_req_d  = bus_req_q;
      bus_addr_d = bus_addr_q;
      dato_d     = dato_q;
      err_d      = err_q;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      advance    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tick_lectura && fc_legal(funcion_conf)) begin
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = ST_CHECK;
            end
         end

         ST_CHECK: begin
            // Skip is evaluated with the live mode so a mid-sweep change takes effect
            // from the next index onwards.
            if (skip_idx(funcion_conf, idx_q)) begin
               advance = 1'b1;
            end else begin
               bus_addr_d = rtc_addr(idx_q);
               bus_req_d  = 1'b1;
               cnt_load   = 1'b1;
               state_d    = ST_WAIT_ACK;
            end
         end

         ST_WAIT_ACK: begin
            cnt_en = 1'b1;
            // Ack is tested first so an ack coinciding with expiry is still taken.
            if (bus_ack) begin
               dato_d    = bus_data_in;
               bus_req_d = 1'b0;
               state_d   = ST_STROBE;
            end else if (cnt_expired) begin
               bus_req_d = 1'b0;
               err_d     = 1'b1;
               advance   = 1'b1;
            end
         end

         ST_STROBE: begin
            advance = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (advance) begin
         if (idx_q == ADDR_W'(N_REGS - 1)) begin
            state_d = ST_IDLE;
         end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_CHECK;
         end
      end

      // Outputs are derived from the next state so they are registered and line up
      // with the state they describe.
      reg_rd_d     = (state_d != ST_STROBE);
      addr_local_d = (state_d == ST_STROBE) ? idx_q : ADDR_IDLE;
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         bus_req_q    <= 1'b0;
         bus_addr_q   <= 8'h00;
         reg_rd_q     <= 1'b1;
         addr_local_q <= ADDR_IDLE;
         dato_q       <= '0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         bus_req_q    <= bus_req_d;
         bus_addr_q   <= bus_addr_d;
         reg_rd_q     <= reg_rd_d;
         addr_local_q <= addr_local_d;
         dato_q       <= dato_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign bus_req        = bus_req_q;
   assign bus_addr       = bus_addr_q;
   assign reg_rd         = reg_rd_q;
   assign addr_mem_local = addr_local_q;
   assign dato_local     = dato_q;
   assign busy           = busy_q;
   assign error_timeout  = err_q;

endmodule

// File: tb/tb_rtc_lectura_secuenciador.sv
// tb/tb_rtc_lectura_secuenciador.sv - self-checking bench for the RTC read sequencer
module tb_rtc_lectura_secuenciador;

   logic       clk;
   logic       reset;
   logic       tick_lectura;
   logic [2:0] funcion_conf;
   logic       bus_ack;
   logic [7:0] bus_data_in;
   logic       bus_req;
   logic [7:0] bus_addr;
   logic       reg_rd;
   logic [3:0] addr_mem_local;
   logic [7:0] dato_local;
   logic       busy;
   logic       error_timeout;

   int checks = 0;
   int errors = 0;

   rtc_lectura_secuenciador #(
      .N_REGS(10), .ADDR_W(4), .DATA_W(8), .TIMEOUT(255)
   ) dut (
      .clk(clk), .reset(reset), .tick_lectura(tick_lectura), .funcion_conf(funcion_conf),
      .bus_ack(bus_ack), .bus_data_in(bus_data_in), .bus_req(bus_req), .bus_addr(bus_addr),
      .reg_rd(reg_rd), .addr_mem_local(addr_mem_local), .dato_local(dato_local),
      .busy(busy), .error_timeout(error_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0] m0;
      logic [2:0] m1;
      int         chg_idx;
      int         to_idx;
      bit         idle_ack;
      int         tick2_rel;
      int         exp_strobes;
      int         exp_busy;
      int         exp_err;
   } vec_t;

   vec_t       tbl[8];
   int         lat_a[10];
   logic [7:0] dat_a[10];
   logic [2:0] cur_m1;
   int         cur_chg;
   bit         cur_idle_ack;
   int         cur_tick2;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit skip_of(input logic [2:0] m, input int i);
      case (m)
         3'b000:  return 1'b0;
         3'b001:  return (i <= 2);
         3'b010:  return (i >= 3 && i <= 6);
         3'b100:  return (i >= 7);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [7:0] addr_of(input int i);
      if (i < 7) return 8'h21 + 8'(i);
      return 8'h41 + 8'(i - 7);
   endfunction

   function automatic int idx_of(input logic [7:0] a);
      for (int i = 0; i < 10; i++) if (addr_of(i) == a) return i;
      return -1;
   endfunction

   task automatic do_sweep(input logic [2:0] m0, input string tag,
                           output int n_str, output int busy_n, output int err_end);
      int q_ea[$], q_el[$], q_sa[$], q_sd[$];
      int q_aa[$], q_al[$], q_as[$], q_ad[$];
      int exp_busy, exp_err, exp_first, first_req;
      int rel, cur_len, bad_strobe, bad_idle, post_bad, i;
      bit done, prev_req;
      logic [2:0] m;

      // Reference model: per-index cost and traffic straight from the sweep rules
      exp_busy = 0; exp_err = 0; exp_first = -1;
      for (int k = 0; k < 10; k++) begin
         m = (cur_chg >= 0 && k > cur_chg) ? cur_m1 : m0;
         if (skip_of(m, k)) begin
            exp_busy += 1;
         end else begin
            if (exp_first < 0) exp_first = 2 + k;
            q_ea.push_back(int'(addr_of(k)));
            if (lat_a[k] < 0) begin
               q_el.push_back(255);
               exp_busy += 256;
               exp_err = 1;
            end else begin
               q_el.push_back(lat_a[k] + 1);
               exp_busy += lat_a[k] + 3;
               q_sa.push_back(k);
               q_sd.push_back(int'(dat_a[k]));
            end
         end
      end

      funcion_conf = m0;
      tick_lectura = 1'b1;
      bus_ack      = cur_idle_ack;
      bus_data_in  = 8'($urandom);
      rel = 0; done = 0; prev_req = 0; cur_len = 0; busy_n = 0;
      first_req = -1; bad_strobe = 0; bad_idle = 0;
      while (!done && rel < 4000) begin
         @(posedge clk); #1;
         rel++;
         if (rel == 1) begin
            chk($sformatf("%s_busy_t1", tag), int'(busy), 1);
            chk($sformatf("%s_err_clr_t1", tag), int'(error_timeout), 0);
         end
         if (bus_req) begin
            if (!prev_req) begin
               q_aa.push_back(int'(bus_addr));
               cur_len = 0;
               if (first_req < 0) first_req = rel;
            end
            cur_len++;
         end else if (prev_req) begin
            q_al.push_back(cur_len);
         end
         if (!reg_rd) begin
            q_as.push_back(int'(addr_mem_local));
            q_ad.push_back(int'(dato_local));
            if (!(prev_req && bus_ack) || bus_req) bad_strobe++;
         end else if (addr_mem_local != 4'hF) begin
            bad_idle++;
         end
         if (busy) busy_n++;
         else done = 1;
         prev_req = bus_req;

         tick_lectura = (rel == cur_tick2);
         if (bus_req) begin
            i = idx_of(bus_addr);
            if (cur_chg >= 0 && i == cur_chg) funcion_conf = cur_m1;
            bus_ack     = cur_idle_ack || (i >= 0 && lat_a[i] >= 0 && cur_len - 1 == lat_a[i]);
            bus_data_in = (i >= 0) ? dat_a[i] : 8'hEE;
         end else begin
            bus_ack     = cur_idle_ack;
            bus_data_in = 8'($urandom);
         end
      end
      chk($sformatf("%s_sweep_ends", tag), int'(done), 1);
      err_end = int'(error_timeout);
      n_str   = q_as.size();

      chk($sformatf("%s_busy_cycles", tag), busy_n, exp_busy);
      chk($sformatf("%s_first_req_rel", tag), first_req, exp_first);
      chk($sformatf("%s_err_end", tag), err_end, exp_err);
      chk($sformatf("%s_strobe_timing", tag), bad_strobe, 0);
      chk($sformatf("%s_idle_addr", tag), bad_idle, 0);
      chk($sformatf("%s_n_strobes", tag), q_as.size(), q_sa.size());
      for (int k = 0; k < q_sa.size() && k < q_as.size(); k++) begin
         chk($sformatf("%s_strobe%0d_addr", tag, k), q_as[k], q_sa[k]);
         chk($sformatf("%s_strobe%0d_data", tag, k), q_ad[k], q_sd[k]);
      end
      chk($sformatf("%s_n_reqs", tag), q_aa.size(), q_ea.size());
      for (int k = 0; k < q_ea.size() && k < q_aa.size(); k++)
         chk($sformatf("%s_req%0d_addr", tag, k), q_aa[k], q_ea[k]);
      for (int k = 0; k < q_el.size() && k < q_al.size(); k++)
         chk($sformatf("%s_req%0d_len", tag, k), q_al[k], q_el[k]);

      // Idle afterwards: stray acks/ticks must not produce strobes; error flag holds
      tick_lectura = 1'b0;
      post_bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (!reg_rd || busy || bus_req || int'(error_timeout) != exp_err) post_bad++;
      end
      chk($sformatf("%s_post_idle", tag), post_bad, 0);
      bus_ack = 1'b0;
      funcion_conf = 3'b000;
   endtask

   initial begin
      int n_str, busy_n, err_end, seen, n_pre, n_post;

      reset = 1'b1; tick_lectura = 1'b0; funcion_conf = 3'b000;
      bus_ack = 1'b0; bus_data_in = 8'h00;
      cur_m1 = 3'b000; cur_chg = -1; cur_idle_ack = 0; cur_tick2 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_req", int'(bus_req), 0);
      chk("rst_bus_addr", int'(bus_addr), 0);
      chk("rst_reg_rd", int'(reg_rd), 1);
      chk("rst_addr_local", int'(addr_mem_local), 15);
      chk("rst_dato", int'(dato_local), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(error_timeout), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Tick with an illegal mode is ignored
      funcion_conf = 3'b011; tick_lectura = 1'b1;
      @(posedge clk); #1;
      tick_lectura = 1'b0;
      chk("illegal_tick_busy", int'(busy), 0);
      @(posedge clk); #1;
      chk("illegal_tick_req", int'(bus_req), 0);
      funcion_conf = 3'b000;

      //            m0      m1      chg to  idle tick2 strobes busy err
      tbl[0] = '{3'b000, 3'b000, -1, -1, 1'b0, 0, 10,  30, 0};
      tbl[1] = '{3'b001, 3'b001, -1, -1, 1'b0, 0,  7,  24, 0};
      tbl[2] = '{3'b010, 3'b010, -1, -1, 1'b0, 0,  6,  22, 0};
      tbl[3] = '{3'b100, 3'b100, -1, -1, 1'b0, 0,  7,  24, 0};
      tbl[4] = '{3'b000, 3'b000, -1,  4, 1'b0, 0,  9, 283, 1};
      tbl[5] = '{3'b000, 3'b010,  2, -1, 1'b0, 0,  6,  22, 0};
      tbl[6] = '{3'b000, 3'b011,  2, -1, 1'b0, 0,  3,  16, 0};
      tbl[7] = '{3'b000, 3'b000, -1, -1, 1'b1, 5, 10,  30, 0};

      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < 10; k++) begin
            lat_a[k] = 0;
            dat_a[k] = 8'h10 + 8'(k);
         end
         if (tbl[v].to_idx >= 0) lat_a[tbl[v].to_idx] = -1;
         cur_m1 = tbl[v].m1; cur_chg = tbl[v].chg_idx;
         cur_idle_ack = tbl[v].idle_ack; cur_tick2 = tbl[v].tick2_rel;
         do_sweep(tbl[v].m0, $sformatf("vec%0d", v), n_str, busy_n, err_end);
         chk($sformatf("vec%0d_tbl_strobes", v), n_str, tbl[v].exp_strobes);
         chk($sformatf("vec%0d_tbl_busy", v), busy_n, tbl[v].exp_busy);
         chk($sformatf("vec%0d_tbl_err", v), err_end, tbl[v].exp_err);
      end
      cur_m1 = 3'b000; cur_chg = -1; cur_idle_ack = 0; cur_tick2 = 0;

      // Asynchronous reset while idx 2 waits for its ack
      funcion_conf = 3'b000; tick_lectura = 1'b1; seen = 0; n_pre = 0;
      for (int c = 0; c < 200 && seen < 3; c++) begin
         @(posedge clk); #1;
         tick_lectura = 1'b0;
         if (!reg_rd) n_pre++;
         if (bus_req && bus_addr == 8'h23) seen++;
         bus_ack = bus_req && (bus_addr != 8'h23);
         bus_data_in = 8'h55;
      end
      chk("rst_mid_reached_idx2", seen, 3);
      chk("rst_mid_pre_strobes", n_pre, 2);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_bus_req", int'(bus_req), 0);
      chk("rst_mid_bus_addr", int'(bus_addr), 0);
      chk("rst_mid_reg_rd", int'(reg_rd), 1);
      chk("rst_mid_addr_local", int'(addr_mem_local), 15);
      chk("rst_mid_dato", int'(dato_local), 0);
      chk("rst_mid_busy", int'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus_ack = 1'b1;
      n_post = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (!reg_rd || busy || bus_req) n_post++;
      end
      chk("rst_mid_no_activity", n_post, 0);
      bus_ack = 1'b0;

      // Randomized sweeps against the reference model
      for (int r = 0; r < 12; r++) begin
         logic [2:0] m0;
         int to_i;
         case ($urandom_range(3))
            0: m0 = 3'b000;
            1: m0 = 3'b001;
            2: m0 = 3'b010;
            default: m0 = 3'b100;
         endcase
         to_i = ($urandom_range(3) == 0) ? int'($urandom_range(9)) : -1;
         for (int k = 0; k < 10; k++) begin
            lat_a[k] = int'($urandom_range(3));
            dat_a[k] = 8'($urandom);
         end
         if (to_i >= 0) lat_a[to_i] = -1;
         cur_chg = -1;
         if ($urandom_range(2) == 0) begin
            cur_chg = int'($urandom_range(9));
            if (skip_of(m0, cur_chg)) cur_chg = -1;
         end
         case ($urandom_range(4))
            0: cur_m1 = 3'b000;
            1: cur_m1 = 3'b001;
            2: cur_m1 = 3'b010;
            3: cur_m1 = 3'b100;
            default: cur_m1 = 3'b110;
         endcase
         cur_idle_ack = 0;
         cur_tick2 = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(20, 3));
         do_sweep(m0, $sformatf("rnd%0d", r), n_str, busy_n, err_end);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_lectura_secuenciador.md
# rtc_lectura_secuenciador

Read sequencer that sweeps the ten local RTC time/date/timer registers. On each read tick it fetches every register from the external RTC bus controller through a req/ack handshake. For each fetched value it presents one active-low `reg_rd` strobe with `addr_mem_local` and `dato_local` to the downstream hold decoder and register bank. It skips the register group currently being configured, as selected by `funcion_conf`.

## Interface
- `N_REGS`, 10: number of local registers swept (local addresses 0..N_REGS-1).
- `ADDR_W`, 4: width of `addr_mem_local`.
- `DATA_W`, 8: RTC data width.
- `TIMEOUT`, 255: WAIT_ACK cycles allowed before a transfer is abandoned.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `tick_lectura` in 1: single-cycle sweep start request.
- `funcion_conf` in 3: mode; 000 normal, 001 config hora, 010 config fecha, 100 config timer.
- `bus_ack` in 1: bus controller ack; `bus_data_in` is valid in the same cycle.
- `bus_data_in` in DATA_W: read data.
- `bus_req` out 1: read request, held until ack or timeout.
- `bus_addr` out 8: RTC address of the current request.
- `reg_rd` out 1: active-low one-cycle load strobe.
- `addr_mem_local` out ADDR_W: local address; valid while `reg_rd`=0.
- `dato_local` out DATA_W: fetched data; valid while `reg_rd`=0.
- `busy` out 1: sweep in progress.
- `error_timeout` out 1: sticky; set on any timeout, cleared at the next accepted tick.

## Operation
- States: IDLE, CHECK, WAIT_ACK, STROBE. Internal index `idx` runs 0..N_REGS-1.
- **IDLE**
  - When `tick_lectura`=1 and `funcion_conf` is one of the four legal codes: set `idx`=0, clear `error_timeout`, go to CHECK.
  - Ticks carrying an illegal `funcion_conf` are ignored.
  - Ticks arriving outside IDLE are ignored.
- **CHECK**
  - Evaluate skip with the live `funcion_conf`:
    - 001 skips idx 0-2.
    - 010 skips idx 3-6.
    - 100 skips idx 7-9.
    - 000 skips none.
    - An illegal code arriving mid-sweep skips all remaining indices.
  - Skip: advance (see below).
  - No skip: load `bus_addr` from the address map, set `bus_req`=1, clear the timeout counter, go to WAIT_ACK.
- **WAIT_ACK**
  - `bus_ack`=1: capture `bus_data_in` into `dato_local`, drop `bus_req`, go to STROBE.
  - Counter reaches TIMEOUT with no ack: drop `bus_req`, set `error_timeout`, advance with no strobe.
  - An ack in the same cycle as the timeout wins.
- **STROBE**
  - One cycle with `reg_rd`=0, `addr_mem_local`=idx, then advance.
- **Advance**
  - idx = N_REGS-1: go to IDLE.
  - Otherwise: idx+1, go to CHECK.
- Outside STROBE: `reg_rd`=1 and `addr_mem_local`=4'hF. 4'hF is a decoder-default address, so no register loads.
- Address map (idx -> `bus_addr`): 0-6 -> 0x21-0x27, 7-9 -> 0x41-0x43.
- `bus_ack` while `bus_req`=0 is ignored.

## Timing
- Reset values:
  - State IDLE, idx 0.
  - `bus_req` 0, `bus_addr` 0x00.
  - `reg_rd` 1, `addr_mem_local` 4'hF, `dato_local` 0.
  - `busy` 0, `error_timeout` 0.
- Reset takes effect immediately, including mid-transfer: `bus_req` drops asynchronously and no strobe is issued after reset.
- All outputs are registered.
- Tick at cycle t:
  - CHECK at t+1; `busy`=1 from t+1.
  - `bus_req`=1 at t+2.
- Ack sampled at cycle a: `reg_rd`=0 at a+1 and `bus_req`=0 at a+1.
- Non-skipped index with ack in the first WAIT_ACK cycle: 3 cycles. Skipped index: 1 cycle.
- Full mode-000 sweep with immediate acks: `busy` high for t+1..t+30, back in IDLE at t+31.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles.
- `busy` falls in the cycle IDLE is entered.

## Structure
- Package `rtc_pkg`:
  - `funcion_conf` code constants.
  - State enum.
  - Local-index to RTC-address map, as a function or constant array.
  - Skip-range constants.
  - Idle address 4'hF.
- One sub-module `rtc_timeout_cnt`: loadable counter that asserts `expired` at TIMEOUT.
- The FSM stays in the top module.

## Test plan
- Mode 000, ack in first WAIT_ACK cycle with data 0x10+idx -> ten strobes, at addr 0..9 with `dato_local` 0x10..0x19. `bus_addr` sequence 0x21..0x27, 0x41..0x43. `busy` high for 30 cycles.
- Mode 001 -> 7 strobes at addr 3..9, no request to 0x21-0x23. Mode 100 -> strobes only at 0..6.
- No ack at idx 4 -> `bus_req` high 255 cycles, no strobe at addr 4. `error_timeout`=1 and stays set through sweep end. The next tick clears it.
- Second tick during a sweep; ack held high while idle -> both ignored, exactly one sweep of strobes.
- Assert `reset` while in WAIT_ACK for idx 2 -> `bus_req`=0 asynchronously, all outputs at reset values, no further strobes until a new tick.
- Change `funcion_conf` 000->010 while idx 2 is in WAIT_ACK -> idx 2 completes, 3-6 skipped, 7-9 strobed.
